aes_wb_sequencer: RTL and testbench



---
 rtl/aes_wb_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_aes_wb_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_wb_sequencer.sv
// Wishbone B3 classic master that runs one AES block operation on aes_top.
// Writes key, data and control registers, polls status, then returns the result.
module aes_wb_sequencer #(
  parameter logic [31:0] AES_BASE  = 32'h0000_0000,
  parameter int          POLL_MAX  = 16,
  parameter bit          KEY_CACHE = 1'b1
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_ni,
  input  logic         cmd_valid_i,
  output logic         cmd_ready_o,
  input  logic [127:0] cmd_key_i,
  input  logic [127:0] cmd_data_i,
  input  logic         cmd_decrypt_i,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic [127:0] rsp_data_o,
  output logic         rsp_err_o,
  output logic         busy_o,
  output logic [31:0]  wbm_adr_o,
  output logic [31:0]  wbm_dat_o,
  output logic [3:0]   wbm_sel_o,
  output logic         wbm_we_o,
  output logic         wbm_cyc_o,
  output logic         wbm_stb_o,
  output logic [2:0]   wbm_cti_o,
  output logic [1:0]   wbm_bte_o,
  input  logic         wbm_ack_i,
  input  logic         wbm_err_i,
  input  logic         wbm_rty_i,
  input  logic [31:0]  wbm_dat_i
);

  localparam int CW = $clog2(POLL_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, WR_KEY, WR_DIN, WR_CTRL, POLL, RD_DOUT, RESP
  } state_t;

  state_t         state;
  logic [1:0]     idx;
  logic [127:0]   key_q;
  logic [127:0]   data_q;
  logic [127:0]   cache_q;
  logic           dec_q;
  logic           key_valid;
  logic [CW-1:0]  poll_cnt;
  logic [7:0]     off;
  logic [31:0]    wdat;
  logic           wr;

  function automatic logic [31:0] pick(logic [127:0] v, logic [1:0] i);
    logic [31:0] w;
    case (i)
      2'd0:    w = v[127:96];
      2'd1:    w = v[95:64];
      2'd2:    w = v[63:32];
      default: w = v[31:0];
    endcase
    return w;
  endfunction

  assign wbm_sel_o = 4'hF;
  assign wbm_cti_o = 3'b000;
  assign wbm_bte_o = 2'b00;
  assign busy_o    = (state != IDLE);

  // Address/data of the access the current state would issue next
  always_comb begin
    off  = 8'h00;
    wdat = 32'h0;
    wr   = 1'b0;
    case (state)
      WR_KEY: begin
        off  = {4'h0, idx, 2'b00};
        wdat = pick(key_q, idx);
        wr   = 1'b1;
      end
      WR_DIN: begin
        off  = {4'h1, idx, 2'b00};
        wdat = pick(data_q, idx);
        wr   = 1'b1;
      end
      WR_CTRL: begin
        off  = 8'h20;
        wdat = {30'h0, dec_q, 1'b1};
        wr   = 1'b1;
      end
      POLL:    off = 8'h24;
      RD_DOUT: off = 8'h28 + {4'h0, idx, 2'b00};
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state       <= IDLE;
      idx         <= 2'd0;
      key_q       <= '0;
      data_q      <= '0;
      cache_q     <= '0;
      dec_q       <= 1'b0;
      key_valid   <= 1'b0;
      poll_cnt    <= '0;
      cmd_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_err_o   <= 1'b0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      wbm_we_o    <= 1'b0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready_o <= 1'b1;
          if (cmd_valid_i && cmd_ready_o) begin
            cmd_ready_o <= 1'b0;
            key_q       <= cmd_key_i;
            data_q      <= cmd_data_i;
            dec_q       <= cmd_decrypt_i;
            idx         <= 2'd0;
            rsp_data_o  <= '0;
            rsp_err_o   <= 1'b0;
            if (KEY_CACHE && key_valid && cmd_key_i == cache_q)
              state <= WR_DIN;
            else
              state <= WR_KEY;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          // Idle bus cycle between accesses issues the next one
          if (!wbm_stb_o) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_adr_o <= AES_BASE + {24'h0, off};
            wbm_dat_o <= wdat;
            wbm_we_o  <= wr;
          end else if (wbm_err_i) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            key_valid   <= 1'b0;
            rsp_data_o  <= '0;
            rsp_err_o   <= 1'b1;
            rsp_valid_o <= 1'b1;
            state       <= RESP;
          end else if (wbm_rty_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
          end else if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            case (state)
              WR_KEY: begin
                idx <= idx + 2'd1;
                if (idx == 2'd3) begin
                  cache_q   <= key_q;
                  key_valid <= 1'b1;
                  state     <= WR_DIN;
                end
              end
              WR_DIN: begin
                idx <= idx + 2'd1;
                if (idx == 2'd3) state <= WR_CTRL;
              end
              WR_CTRL: begin
                poll_cnt <= '0;
                state    <= POLL;
              end
              POLL: begin
                if (wbm_dat_i[0]) begin
                  idx   <= 2'd0;
                  state <= RD_DOUT;
                end else begin
                  poll_cnt <= poll_cnt + 1'b1;
                  if (poll_cnt == CW'(POLL_MAX - 1)) begin
                    key_valid   <= 1'b0;
                    rsp_data_o  <= '0;
                    rsp_err_o   <= 1'b1;
                    rsp_valid_o <= 1'b1;
                    state       <= RESP;
                  end
                end
              end
              RD_DOUT: begin
                case (idx)
                  2'd0:    rsp_data_o[127:96] <= wbm_dat_i;
                  2'd1:    rsp_data_o[95:64]  <= wbm_dat_i;
                  2'd2:    rsp_data_o[63:32]  <= wbm_dat_i;
                  default: rsp_data_o[31:0]   <= wbm_dat_i;
                endcase
                idx <= idx + 2'd1;
                if (idx == 2'd3) begin
                  rsp_valid_o <= 1'b1;
                  state       <= RESP;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_wb_sequencer.sv
// Directed bench for aes_wb_sequencer with a behavioural aes_top slave.
// Slave returns known-answer AES vectors and logs every bus access.
module tb_aes_wb_sequencer;

  localparam logic [31:0]  B  = 32'h4000_0000;
  localparam logic [127:0] K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid, cmd_ready, cmd_dec;
  logic [127:0] cmd_key, cmd_data;
  logic         rsp_valid, rsp_ready, rsp_err, busy;
  logic [127:0] rsp_data;
  logic [31:0]  adr, wdat, rdat;
  logic [3:0]   sel;
  logic         we, cyc, stb, ack, err, rty;
  logic [2:0]   cti;
  logic [1:0]   bte;

  always #5 clk = ~clk;

  aes_wb_sequencer #(.AES_BASE(B), .POLL_MAX(8), .KEY_CACHE(1'b1)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_key_i(cmd_key), .cmd_data_i(cmd_data), .cmd_decrypt_i(cmd_dec),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_err_o(rsp_err), .busy_o(busy),
    .wbm_adr_o(adr), .wbm_dat_o(wdat), .wbm_sel_o(sel), .wbm_we_o(we),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_cti_o(cti), .wbm_bte_o(bte),
    .wbm_ack_i(ack), .wbm_err_i(err), .wbm_rty_i(rty), .wbm_dat_i(rdat)
  );

  // slave controls owned by the stimulus process
  logic        never_done, clr_req, rty_req;
  logic [31:0] err_adr;

  // slave state owned by the slave process
  logic [31:0]  kr [4];
  logic [31:0]  dr [4];
  logic [127:0] dout;
  logic [31:0]  ctrl_val, off;
  int n_key, n_din, n_stat, n_rty, polls, n_after_err, gap_viol;
  logic err_seen, rty_used, rty_pend, term_prev;
  logic [31:0] rty_adr, rty_dat, nxt_adr, nxt_dat;

  assign off = adr - B;
  assign err = cyc && stb && adr == err_adr;
  assign rty = cyc && stb && !err && rty_req && !rty_used && off == 32'h4;
  assign ack = cyc && stb && !err && !rty;

  always_comb begin
    rdat = 32'h0;
    case (off)
      32'h24: rdat = {31'h0, !never_done && polls >= 2};
      32'h28: rdat = dout[127:96];
      32'h2c: rdat = dout[95:64];
      32'h30: rdat = dout[63:32];
      32'h34: rdat = dout[31:0];
      default: ;
    endcase
  end

  always @(posedge clk) begin
    if (term_prev && cyc) gap_viol <= gap_viol + 1;
    term_prev <= cyc && stb && (ack || err || rty);
    if (clr_req) begin
      n_key <= 0; n_din <= 0; n_stat <= 0; n_rty <= 0;
      n_after_err <= 0; err_seen <= 1'b0; rty_used <= 1'b0;
      rty_pend <= 1'b0; ctrl_val <= 32'hffff_ffff;
    end else begin
      if (err_seen && cyc) n_after_err <= n_after_err + 1;
      if (cyc && stb && err) err_seen <= 1'b1;
      if (cyc && stb && rty) begin
        rty_used <= 1'b1; rty_pend <= 1'b1; n_rty <= n_rty + 1;
        rty_adr <= adr; rty_dat <= wdat;
      end
      if (cyc && stb && rty_pend && (ack || err || rty)) begin
        rty_pend <= 1'b0; nxt_adr <= adr; nxt_dat <= wdat;
      end
      if (ack && !we && off == 32'h24) begin
        n_stat <= n_stat + 1;
        polls  <= polls + 1;
      end
      if (ack && we) begin
        if (off < 32'h10) begin
          kr[off[3:2]] <= wdat; n_key <= n_key + 1;
        end else if (off < 32'h20) begin
          dr[off[3:2]] <= wdat; n_din <= n_din + 1;
        end else if (off == 32'h20) begin
          ctrl_val <= wdat;
          polls    <= 0;
          if ({kr[0], kr[1], kr[2], kr[3]} == K &&
              {dr[0], dr[1], dr[2], dr[3]} == (wdat[1] ? CT : PT))
            dout <= wdat[1] ? PT : CT;
          else
            dout <= {4{32'hbad0_bad0}};
        end
      end
    end
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr();
    @(negedge clk); clr_req = 1'b1;
    @(negedge clk); clr_req = 1'b0;
  endtask

  task automatic send(input logic [127:0] k, input logic [127:0] d,
                      input logic dec);
    int n = 0;
    @(negedge clk);
    cmd_key = k; cmd_data = d; cmd_dec = dec; cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("cmd_ready_timeout", 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk); cmd_valid = 1'b0;
  endtask

  task automatic get(input int hold, output logic [127:0] d, output logic e);
    int  n = 0;
    logic ok = 1'b1;
    d = '0; e = 1'b0;
    while (!rsp_valid && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) begin
      chk("rsp_timeout", 1'b0, 1'b1);
      return;
    end
    d = rsp_data; e = rsp_err;
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        if (!rsp_valid || rsp_data !== d || rsp_err !== e || cmd_ready) ok = 1'b0;
      end
      chk("rsp_hold_stable", ok, 1'b1);
    end
    rsp_ready = 1'b1;
    @(negedge clk); rsp_ready = 1'b0;
    if (hold > 0) begin
      chk("ready_after_rsp", cmd_ready, 1'b1);
      chk("valid_after_rsp", rsp_valid, 1'b0);
    end
  endtask

  logic [127:0] d;
  logic         e;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_key = '0; cmd_data = '0;
    cmd_dec = 1'b0; rsp_ready = 1'b0; never_done = 1'b0; rty_req = 1'b0;
    clr_req = 1'b1; err_adr = 32'hffff_fff0;
    gap_viol = 0; term_prev = 1'b0; polls = 0;
    repeat (3) @(negedge clk);
    chk("rst_cyc_stb", {cyc, stb, we}, 3'b000);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_data}, '0);
    chk("rst_ready_busy", {cmd_ready, busy}, 2'b00);
    chk("rst_adr_dat", {adr, wdat}, 64'h0);
    rst_n = 1'b1; clr_req = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1'b1);

    // encrypt with cold key cache
    clr(); send(K, PT, 1'b0); get(0, d, e);
    chk("enc_key_writes", n_key, 4);
    chk("enc_din_writes", n_din, 4);
    chk("enc_ctrl", ctrl_val, 32'h1);
    chk("enc_key_regs", {kr[0], kr[1], kr[2], kr[3]}, K);
    chk("enc_data", d, CT);
    chk("enc_err", e, 1'b0);

    // decrypt, key now cached
    clr(); send(K, CT, 1'b1); get(0, d, e);
    chk("dec_key_writes", n_key, 0);
    chk("dec_ctrl", ctrl_val, 32'h3);
    chk("dec_data", d, PT);
    chk("dec_err", e, 1'b0);

    // poll timeout
    never_done = 1'b1;
    clr(); send(K, PT, 1'b0); get(0, d, e);
    chk("tmo_status_reads", n_stat, 8);
    chk("tmo_err", e, 1'b1);
    chk("tmo_data", d, '0);
    never_done = 1'b0;
    clr(); send(K, PT, 1'b0); get(0, d, e);
    chk("tmo_key_rewrite", n_key, 4);
    chk("tmo_next_data", d, CT);

    // bus error on DIN2
    err_adr = B + 32'h18;
    clr(); send(K, PT, 1'b0); get(0, d, e);
    err_adr = 32'hffff_fff0;
    chk("berr_err", e, 1'b1);
    chk("berr_data", d, '0);
    chk("berr_din_acks", n_din, 2);
    chk("berr_cyc_after", n_after_err, 0);

    // one retry on KEY1
    rty_req = 1'b1;
    clr(); send(K, PT, 1'b0); get(0, d, e);
    rty_req = 1'b0;
    chk("rty_count", n_rty, 1);
    chk("rty_reissue", {nxt_adr, nxt_dat}, {rty_adr, rty_dat});
    chk("rty_key1", {rty_adr, rty_dat}, {B + 32'h4, K[95:64]});
    chk("rty_key_writes", n_key, 4);
    chk("rty_data", d, CT);
    chk("rty_err", e, 1'b0);

    // response backpressure
    clr(); send(K, CT, 1'b1); get(10, d, e);
    chk("bp_data", d, PT);

    // reset while polling
    never_done = 1'b1;
    clr(); send(K, PT, 1'b0);
    begin
      int n = 0;
      while (!(n_stat >= 2 && cyc) && n < 200) begin @(negedge clk); n++; end
      chk("poll_reached", n < 200, 1'b1);
    end
    #1 rst_n = 1'b0;
    #1;
    chk("arst_bus", {cyc, stb}, 2'b00);
    chk("arst_rsp_busy", {rsp_valid, busy}, 2'b00);
    @(negedge clk); rst_n = 1'b1; never_done = 1'b0;
    clr(); send(K, PT, 1'b0); get(0, d, e);
    chk("arst_key_rewrite", n_key, 4);
    chk("arst_data", d, CT);
    chk("bus_gap", gap_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
